// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter slice.
//   tx_state_e          : transmitter FSM state encoding
//   DEFAULT_CLK_PER_BIT : 100 MHz / 115200 baud
//   DATA_BITS/STOP_BITS : 8N1 frame shape
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLK_PER_BIT = 868;
  localparam int DATA_BITS           = 8;
  localparam int STOP_BITS           = 1;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte-offer handshake plus serial/status outputs of uart_tx.
//   tx_data/new_tx_data : byte offered by the host (master -> slave)
//   tx_busy             : FIFO full (slave -> master, combinational)
//   tx/tx_idle          : serial line and "nothing left to send"
//   tx_overflow         : one-cycle pulse, a strobe was dropped
//   state               : FSM state, exposed for debug/checkers
//
// Handshake: new_tx_data is a single-cycle strobe. On a rising edge with
// new_tx_data=1 the byte is accepted when tx_busy=0; when tx_busy=1 it is
// dropped and tx_overflow is high for the next cycle. There is no retry.
interface uart_tx_if import uart_pkg::*; ();

  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic       tx;
  logic       tx_idle;
  logic       tx_overflow;
  tx_state_e  state;

  modport master (
    output tx_data, new_tx_data,
    input  tx_busy, tx, tx_idle, tx_overflow, state
  );

  modport slave (
    input  tx_data, new_tx_data,
    output tx_busy, tx, tx_idle, tx_overflow, state
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO with first-word-fall-through output.
//   clk, rst   : clock, asynchronous active-high reset (flushes contents)
//   push, din  : write; ignored while full (no pop-rescue on the same edge)
//   pop, dout  : read; dout always shows the head entry
//   full/empty : occupancy flags derived from the count
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // full is the pre-edge value, so a pop on the same edge never frees a slot
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- buffered 8N1 UART transmitter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_tx_if.slave (byte strobe in; tx, tx_busy, tx_idle,
//              tx_overflow and FSM state out)
// The FSM pops the FIFO in IDLE, or at the end of STOP for back-to-back
// frames, so consecutive bytes leave with no idle gap.
module uart_tx import uart_pkg::*; #(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int                BAUD_W    = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e         state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic              tx_q, tx_nxt;
  logic              overflow_q;
  logic              baud_end;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_dout;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.new_tx_data),
    .pop   (fifo_pop),
    .din   (bus.tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    tx_nxt    = tx_q;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_nxt = fifo_dout;
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
          state_nxt = ST_DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_idx == LAST_BIT) begin
            tx_nxt    = 1'b1;
            state_nxt = ST_STOP;
          end else begin
            // shreg[0] is the bit on the line; the next one is shreg[1]
            bit_nxt   = bit_idx + 1'b1;
            shreg_nxt = {1'b0, shreg[7:1]};
            tx_nxt    = shreg[1];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shreg_nxt = fifo_dout;
            tx_nxt    = 1'b0;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_idx    <= bit_nxt;
      shreg      <= shreg_nxt;
      tx_q       <= tx_nxt;
      overflow_q <= bus.new_tx_data && fifo_full;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.tx_overflow = overflow_q;
  assign bus.tx_busy     = fifo_full;
  assign bus.tx_idle     = (state == ST_IDLE) && fifo_empty;
  assign bus.state       = state;

endmodule
